// File: rtl/data_c_pipe_share_arb.sv
// Round-robin front/back end that shares one in-order data_c pipeline among NUM requesters.
// Issue beats are tagged with their source in a FIFO so in-order returns can be steered back.
module data_c_pipe_share_arb #(
    parameter int NUM     = 4,
    parameter int DSIZE   = 32,
    parameter int MAX_OUT = 8
) (
    input  logic                               clock,
    input  logic                               rst,
    input  logic [NUM-1:0]                     req_valid,
    input  logic [NUM-1:0][DSIZE-1:0]          req_data,
    output logic [NUM-1:0]                     req_ready,
    output logic                               pipe_in_valid,
    output logic [DSIZE-1:0]                   pipe_in_data,
    input  logic                               pipe_in_ready,
    input  logic                               pipe_out_valid,
    input  logic [DSIZE-1:0]                   pipe_out_data,
    output logic                               pipe_out_ready,
    output logic [NUM-1:0]                     rsp_valid,
    output logic [DSIZE-1:0]                   rsp_data,
    input  logic [NUM-1:0]                     rsp_ready,
    output logic [$clog2(MAX_OUT+1)-1:0]       outstanding,
    output logic                               err_orphan
);

    localparam int TW = $clog2(NUM);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [TW-1:0]    last;
    logic             grant_any;
    logic [TW-1:0]    grant_idx;
    logic             credit_ok;
    logic             issue_free;
    logic             accept;

    logic             issue_vld_p1;
    logic [DSIZE-1:0] issue_data_p1;

    logic [TW-1:0]    tag_mem [MAX_OUT];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [TW-1:0]    head;
    logic             tag_ne;
    logic             pop;
    logic [CW-1:0]    out_cnt;
    logic             orphan;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(MAX_OUT - 1)) ? '0 : p + AW'(1);
    endfunction

    // Stage p0: combinational round-robin grant from the registered pointer
    always_comb begin
        logic [TW-1:0] cand;
        cand      = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= NUM; i++) begin
            cand = TW'((int'(last) + i) % NUM);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Credit uses the registered count only, so a same-cycle return never frees a slot early.
    assign credit_ok  = (out_cnt < CW'(MAX_OUT));
    assign issue_free = !issue_vld_p1 || pipe_in_ready;
    assign accept     = !rst && grant_any && credit_ok && issue_free;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Return steering: the tag FIFO head names the owner of the oldest in-flight beat.
    assign head   = tag_mem[rd_ptr];
    assign tag_ne = (out_cnt != '0);

    assign pipe_out_ready = tag_ne && rsp_ready[head];
    assign pop            = pipe_out_valid && pipe_out_ready;
    assign rsp_data       = pipe_out_data;

    always_comb begin
        rsp_valid = '0;
        if (!rst && pipe_out_valid && tag_ne) begin
            rsp_valid[head] = 1'b1;
        end
    end

    // Stage p1: issue register and bookkeeping (control state only is reset)
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            issue_vld_p1 <= 1'b0;
            last         <= TW'(NUM - 1);
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_cnt      <= '0;
            orphan       <= 1'b0;
        end else begin
            if (accept) begin
                issue_vld_p1 <= 1'b1;
                last         <= grant_idx;
                wr_ptr       <= ptr_inc(wr_ptr);
            end else if (pipe_in_ready) begin
                issue_vld_p1 <= 1'b0;
            end

            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            case ({accept, pop})
                2'b10:   out_cnt <= out_cnt + CW'(1);
                2'b01:   out_cnt <= out_cnt - CW'(1);
                default: out_cnt <= out_cnt;
            endcase

            if (pipe_out_valid && !tag_ne) begin
                orphan <= 1'b1;
            end
        end
    end

    // Stage p1 payload: held while stalled because it only loads on acceptance
    always_ff @(posedge clock) begin
        if (accept) begin
            issue_data_p1   <= req_data[grant_idx];
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    assign pipe_in_valid = issue_vld_p1;
    assign pipe_in_data  = issue_data_p1;
    assign outstanding   = out_cnt;
    assign err_orphan    = orphan;

endmodule
